// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
//   Shared definitions for the RV32 multi-cycle control sequencer: the FSM
//   state encoding, the decoder instruction-class encoding and trap causes.
//   Ports: none (package).
// -----------------------------------------------------------------------------
package cpu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_HALT   = 3'd6,
        ST_TRAP   = 3'd7
    } ctrl_state_t;

    // Decoder instruction classes. Load/store carry the access size in [1:0].
    localparam logic [4:0] INST_ILLEGAL   = 5'b00000;
    localparam logic [4:0] INST_IMM       = 5'b00001;
    localparam logic [4:0] INST_REG       = 5'b00010;
    localparam logic [4:0] INST_UPP       = 5'b00011;
    localparam logic [4:0] INST_JUMP      = 5'b00100;
    localparam logic [2:0] INST_LOAD_PFX  = 3'b010;
    localparam logic [2:0] INST_STORE_PFX = 3'b011;
    localparam logic [1:0] INST_SYS_PFX   = 2'b10;

    localparam logic [1:0] CAUSE_NONE    = 2'd0;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'd2;

    function automatic logic is_load(input logic [4:0] cls);
        return cls[4:2] == INST_LOAD_PFX;
    endfunction

    function automatic logic is_store(input logic [4:0] cls);
        return cls[4:2] == INST_STORE_PFX;
    endfunction

    function automatic logic is_sys(input logic [4:0] cls);
        return cls[4:3] == INST_SYS_PFX;
    endfunction

    // Classes that produce a register-file result in WB.
    function automatic logic writes_rd(input logic [4:0] cls);
        return (cls == INST_IMM) || (cls == INST_REG) || (cls == INST_UPP) ||
               (cls == INST_JUMP) || is_load(cls) || is_sys(cls);
    endfunction

endpackage

// File: rtl/cpu_ctrl_if.sv
// -----------------------------------------------------------------------------
// cpu_ctrl_if
//   Bundle between the control sequencer and the decoder / memory port /
//   datapath strobes.
//   master: the sequencer (drives memory request and write strobes).
//   slave : the surrounding core (drives class, rd_is_zero, ack, halt).
// -----------------------------------------------------------------------------
interface cpu_ctrl_if;
    logic [4:0] inst_type;
    logic       rd_is_zero;
    logic       mem_ack;
    logic       halt_req;
    logic       mem_req;
    logic       mem_is_fetch;
    logic       mem_we;
    logic [1:0] mem_size;
    logic       ir_we;
    logic       pc_we;
    logic       pc_sel_jump;
    logic       rf_we;
    logic       csr_we;
    logic       retire;
    logic       halted;
    logic       trap;
    logic [1:0] trap_cause;

    modport master (
        input  inst_type, rd_is_zero, mem_ack, halt_req,
        output mem_req, mem_is_fetch, mem_we, mem_size, ir_we, pc_we, pc_sel_jump,
               rf_we, csr_we, retire, halted, trap, trap_cause
    );

    modport slave (
        output inst_type, rd_is_zero, mem_ack, halt_req,
        input  mem_req, mem_is_fetch, mem_we, mem_size, ir_we, pc_we, pc_sel_jump,
               rf_we, csr_we, retire, halted, trap, trap_cause
    );
endinterface

// File: rtl/bus_timeout.sv
// -----------------------------------------------------------------------------
// bus_timeout
//   Counts cycles a memory request waits without acknowledge and flags expiry.
//   Ports:
//     clock, reset_n : clock / async active-low reset
//     i_clear        : zero the count (entry to a request phase)
//     i_req, i_ack   : request pending / acknowledged this cycle
//     o_expire       : count at MEM_TIMEOUT-1 and still no ack this cycle
// -----------------------------------------------------------------------------
module bus_timeout #(
    parameter int unsigned MEM_TIMEOUT = 256
) (
    input  logic clock,
    input  logic reset_n,
    input  logic i_clear,
    input  logic i_req,
    input  logic i_ack,
    output logic o_expire
);
    localparam int unsigned LP_CNT_W = $clog2(MEM_TIMEOUT);
    localparam logic [LP_CNT_W-1:0] LP_LIMIT = LP_CNT_W'(MEM_TIMEOUT - 1);

    logic [LP_CNT_W-1:0] r_cnt;
    logic                w_at_limit;

    assign w_at_limit = (r_cnt == LP_LIMIT);
    // An ack in the limit cycle suppresses expiry.
    assign o_expire   = i_req && !i_ack && w_at_limit;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (i_clear || i_ack) begin
            r_cnt <= '0;
        end else if (i_req && !w_at_limit) begin
            r_cnt <= r_cnt + LP_CNT_W'(1);
        end
    end
endmodule

// File: rtl/cpu_ctrl.sv
// -----------------------------------------------------------------------------
// cpu_ctrl
//   Multi-cycle control sequencer: FETCH, DECODE, EXEC, MEM, WB over a single
//   shared memory port, plus debug HALT and a terminal TRAP state.
//   Ports:
//     clock, reset_n : clock / async active-low reset
//     bus            : cpu_ctrl_if.master (class in, memory request and strobes out)
//     cycle_cnt, instret_cnt : performance counters, only with
//                      CPU_CTRL_PERF_CNT_EN defined
//   Outputs are decoded from state and the latched class, except ir_we and
//   the store-completion pc_we/retire which follow mem_ack combinationally.
// -----------------------------------------------------------------------------
module cpu_ctrl
    import cpu_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 256
`ifdef CPU_CTRL_PERF_CNT_EN
    ,
    parameter int unsigned CNT_W = 32
`endif
) (
    input  logic              clock,
    input  logic              reset_n,
    cpu_ctrl_if.master        bus
`ifdef CPU_CTRL_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]  cycle_cnt,
    output logic [CNT_W-1:0]  instret_cnt
`endif
);
    localparam logic [2:0] S_IDLE   = ST_IDLE;
    localparam logic [2:0] S_FETCH  = ST_FETCH;
    localparam logic [2:0] S_DECODE = ST_DECODE;
    localparam logic [2:0] S_EXEC   = ST_EXEC;
    localparam logic [2:0] S_MEM    = ST_MEM;
    localparam logic [2:0] S_WB     = ST_WB;
    localparam logic [2:0] S_HALT   = ST_HALT;
    localparam logic [2:0] S_TRAP   = ST_TRAP;

    logic [2:0] r_state;
    logic [2:0] w_state_d;
    logic [4:0] r_cls;
    logic [1:0] r_cause;
    logic [1:0] w_cause_d;
    logic       w_ack;
    logic       w_expire;
    logic       w_tmo_clear;

    assign w_ack       = bus.mem_req & bus.mem_ack;
    assign w_tmo_clear = (w_state_d != r_state) &&
                         ((w_state_d == S_FETCH) || (w_state_d == S_MEM));

    bus_timeout #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_bus_timeout (
        .clock    (clock),
        .reset_n  (reset_n),
        .i_clear  (w_tmo_clear),
        .i_req    (bus.mem_req),
        .i_ack    (w_ack),
        .o_expire (w_expire)
    );

    always_comb begin
        w_state_d = r_state;
        w_cause_d = r_cause;
        case (r_state)
            S_IDLE:   w_state_d = bus.halt_req ? S_HALT : S_FETCH;
            S_FETCH: begin
                if (bus.mem_ack) begin
                    w_state_d = S_DECODE;
                end else if (w_expire) begin
                    w_state_d = S_TRAP;
                    w_cause_d = CAUSE_TIMEOUT;
                end
            end
            S_DECODE: begin
                if (bus.inst_type == INST_ILLEGAL) begin
                    w_state_d = S_TRAP;
                    w_cause_d = CAUSE_ILLEGAL;
                end else begin
                    w_state_d = S_EXEC;
                end
            end
            S_EXEC:   w_state_d = (is_load(r_cls) || is_store(r_cls)) ? S_MEM : S_WB;
            S_MEM: begin
                if (bus.mem_ack) begin
                    // A store retires here, so it is an instruction boundary.
                    if (is_store(r_cls)) begin
                        w_state_d = bus.halt_req ? S_HALT : S_FETCH;
                    end else begin
                        w_state_d = S_WB;
                    end
                end else if (w_expire) begin
                    w_state_d = S_TRAP;
                    w_cause_d = CAUSE_TIMEOUT;
                end
            end
            S_WB:     w_state_d = bus.halt_req ? S_HALT : S_FETCH;
            S_HALT:   w_state_d = bus.halt_req ? S_HALT : S_FETCH;
            S_TRAP:   w_state_d = S_TRAP;
            default:  w_state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_cls   <= '0;
            r_cause <= CAUSE_NONE;
        end else begin
            r_state <= w_state_d;
            r_cause <= w_cause_d;
            if (r_state == S_DECODE) begin
                r_cls <= bus.inst_type;
            end
        end
    end

    always_comb begin
        bus.mem_req      = 1'b0;
        bus.mem_is_fetch = 1'b0;
        bus.mem_we       = 1'b0;
        bus.mem_size     = 2'd0;
        bus.ir_we        = 1'b0;
        bus.pc_we        = 1'b0;
        bus.pc_sel_jump  = 1'b0;
        bus.rf_we        = 1'b0;
        bus.csr_we       = 1'b0;
        bus.retire       = 1'b0;
        bus.halted       = 1'b0;
        bus.trap         = 1'b0;
        case (r_state)
            S_FETCH: begin
                bus.mem_req      = 1'b1;
                bus.mem_is_fetch = 1'b1;
                bus.mem_size     = 2'd2;
                bus.ir_we        = bus.mem_ack;
            end
            S_MEM: begin
                bus.mem_req  = 1'b1;
                bus.mem_we   = is_store(r_cls);
                bus.mem_size = r_cls[1:0];
                bus.pc_we    = is_store(r_cls) & bus.mem_ack;
                bus.retire   = is_store(r_cls) & bus.mem_ack;
            end
            S_WB: begin
                bus.rf_we       = writes_rd(r_cls) & ~bus.rd_is_zero;
                bus.csr_we      = is_sys(r_cls);
                bus.pc_we       = 1'b1;
                bus.pc_sel_jump = (r_cls == INST_JUMP);
                bus.retire      = 1'b1;
            end
            S_HALT:  bus.halted = 1'b1;
            S_TRAP:  bus.trap   = 1'b1;
            default: ;
        endcase
    end

    assign bus.trap_cause = r_cause;

`ifdef CPU_CTRL_PERF_CNT_EN
    logic [CNT_W-1:0] r_cycle_cnt;
    logic [CNT_W-1:0] r_instret_cnt;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_cycle_cnt   <= '0;
            r_instret_cnt <= '0;
        end else begin
            if ((r_state != S_IDLE) && (r_state != S_HALT) && (r_state != S_TRAP)) begin
                r_cycle_cnt <= r_cycle_cnt + CNT_W'(1);
            end
            if (bus.retire) begin
                r_instret_cnt <= r_instret_cnt + CNT_W'(1);
            end
        end
    end

    assign cycle_cnt   = r_cycle_cnt;
    assign instret_cnt = r_instret_cnt;
`endif
endmodule
